multi_channel_inertial_filter: RTL and testbench

// N-channel inertial (debounce) filter with independent rise/fall persistence thresholds.

---
 rtl/multi_channel_inertial_filter.sv | 112 +++++++++++
 tb/tb_multi_channel_inertial_filter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_inertial_filter.sv
// rtl/multi_channel_inertial_filter.sv - N-channel inertial (debounce) filter with rise/fall persistence
//
// Purpose:
//   Each channel's output follows its input only after the input has differed
//   from the output for a programmed number of consecutive clock-enabled cycles.
//   Shorter glitches are rejected. One-cycle edge pulses and a per-channel
//   settling flag are provided so consumers need no edge detector.
//
// Ports:
//   clk          rising-edge clock
//   async_reset  asynchronous active-high reset (loads INIT_VALUE, clears state)
//   CE           clock enable; filter state advances only when CE=1
//   synch_reset  synchronous re-seed of outputs from inputs, qualified by CE
//   data_in      raw inputs, already synchronised to clk
//   data_out     filtered outputs (registered)
//   rise_pulse   one-clk pulse when data_out[i] goes 0->1
//   fall_pulse   one-clk pulse when data_out[i] goes 1->0
//   settling     registered count[i]!=0 (a candidate change is being timed)

module multi_channel_inertial_filter #(
    parameter int CHANNELS   = 4,
    parameter int RISE_COUNT = 10,
    parameter int FALL_COUNT = 10,
    parameter bit INIT_VALUE = 1'b0,
    localparam int MAX_COUNT = (RISE_COUNT > FALL_COUNT) ? RISE_COUNT : FALL_COUNT,
    localparam int CNT_W     = $clog2(MAX_COUNT + 1)
) (
    input  logic                clk,
    input  logic                async_reset,
    input  logic                CE,
    input  logic                synch_reset,
    input  logic [CHANNELS-1:0] data_in,
    output logic [CHANNELS-1:0] data_out,
    output logic [CHANNELS-1:0] rise_pulse,
    output logic [CHANNELS-1:0] fall_pulse,
    output logic [CHANNELS-1:0] settling
);

    // Terminal counts: the change commits on the edge where the count already
    // holds TH-1, i.e. on the TH-th consecutive differing sample.
    localparam logic [CNT_W-1:0] RISE_M1 = CNT_W'(RISE_COUNT - 1);
    localparam logic [CNT_W-1:0] FALL_M1 = CNT_W'(FALL_COUNT - 1);

    logic [CHANNELS-1:0] r_out;
    logic [CHANNELS-1:0] r_rise;
    logic [CHANNELS-1:0] r_fall;
    logic [CHANNELS-1:0] r_settle;
    logic [CNT_W-1:0]    r_cnt [CHANNELS];

    logic [CHANNELS-1:0] w_out_nxt;
    logic [CHANNELS-1:0] w_rise_nxt;
    logic [CHANNELS-1:0] w_fall_nxt;
    logic [CHANNELS-1:0] w_settle_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt [CHANNELS];

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            // Hold state and drop pulses by default; pulses therefore last one
            // clk even when CE is low on the following edge.
            w_out_nxt[i]  = r_out[i];
            w_cnt_nxt[i]  = r_cnt[i];
            w_rise_nxt[i] = 1'b0;
            w_fall_nxt[i] = 1'b0;
            if (CE) begin
                if (synch_reset) begin
                    // Silent re-seed: no edge pulse.
                    w_out_nxt[i] = data_in[i];
                    w_cnt_nxt[i] = '0;
                end else if (data_in[i] == r_out[i]) begin
                    w_cnt_nxt[i] = '0;
                end else if (r_cnt[i] == (data_in[i] ? RISE_M1 : FALL_M1)) begin
                    // Threshold follows the current input, so a mid-run flip
                    // (which resets the count via the match branch) never commits.
                    w_out_nxt[i]  = data_in[i];
                    w_cnt_nxt[i]  = '0;
                    w_rise_nxt[i] = data_in[i];
                    w_fall_nxt[i] = ~data_in[i];
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + 1'b1;
                end
            end
            // With CE low the count holds, so this also holds settling.
            w_settle_nxt[i] = (w_cnt_nxt[i] != '0);
        end
    end

    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            r_out    <= {CHANNELS{INIT_VALUE}};
            r_rise   <= '0;
            r_fall   <= '0;
            r_settle <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_out    <= w_out_nxt;
            r_rise   <= w_rise_nxt;
            r_fall   <= w_fall_nxt;
            r_settle <= w_settle_nxt;
            for (int i = 0; i < CHANNELS; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
        end
    end

    assign data_out   = r_out;
    assign rise_pulse = r_rise;
    assign fall_pulse = r_fall;
    assign settling   = r_settle;

endmodule

// File: tb/tb_multi_channel_inertial_filter.sv
// tb/tb_multi_channel_inertial_filter.sv - scoreboard bench for multi_channel_inertial_filter
//
// Two instances share stimulus: A uses RISE/FALL=10/10 with INIT_VALUE=1,
// B uses RISE/FALL=3/7 with INIT_VALUE=0.

module tb_multi_channel_inertial_filter;

    logic       clk = 1'b0;
    logic       async_reset;
    logic       ce;
    logic       synch_reset;
    logic [3:0] data_in;

    logic [3:0] a_out, a_rise, a_fall, a_set;
    logic [3:0] b_out, b_rise, b_fall, b_set;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    multi_channel_inertial_filter #(
        .CHANNELS(4), .RISE_COUNT(10), .FALL_COUNT(10), .INIT_VALUE(1'b1)
    ) u_a (
        .clk(clk), .async_reset(async_reset), .CE(ce), .synch_reset(synch_reset),
        .data_in(data_in), .data_out(a_out), .rise_pulse(a_rise),
        .fall_pulse(a_fall), .settling(a_set)
    );

    multi_channel_inertial_filter #(
        .CHANNELS(4), .RISE_COUNT(3), .FALL_COUNT(7), .INIT_VALUE(1'b0)
    ) u_b (
        .clk(clk), .async_reset(async_reset), .CE(ce), .synch_reset(synch_reset),
        .data_in(data_in), .data_out(b_out), .rise_pulse(b_rise),
        .fall_pulse(b_fall), .settling(b_set)
    );

    // Reference model: length of the current run of differing samples per channel.
    int              m_run [2][4];
    logic [1:0][3:0] m_out, m_rise, m_fall, m_set;
    int              m_rth [2] = '{10, 3};
    int              m_fth [2] = '{10, 7};
    logic            m_init[2] = '{1'b1, 1'b0};

    typedef struct packed {
        logic [1:0][3:0] out;
        logic [1:0][3:0] rise;
        logic [1:0][3:0] fall;
        logic [1:0][3:0] set;
    } exp_t;

    exp_t q[$];

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            m_out[d]  = {4{m_init[d]}};
            m_rise[d] = '0;
            m_fall[d] = '0;
            m_set[d]  = '0;
            for (int c = 0; c < 4; c++) m_run[d][c] = 0;
        end
    endfunction

    function automatic void model_edge(input logic c_e, input logic s_r, input logic [3:0] din);
        for (int d = 0; d < 2; d++) begin
            m_rise[d] = '0;
            m_fall[d] = '0;
            if (c_e) begin
                for (int c = 0; c < 4; c++) begin
                    if (s_r) begin
                        m_out[d][c] = din[c];
                        m_run[d][c] = 0;
                    end else if (din[c] == m_out[d][c]) begin
                        m_run[d][c] = 0;
                    end else begin
                        m_run[d][c]++;
                        if (m_run[d][c] == (din[c] ? m_rth[d] : m_fth[d])) begin
                            m_out[d][c] = din[c];
                            m_run[d][c] = 0;
                            if (din[c]) m_rise[d][c] = 1'b1;
                            else        m_fall[d][c] = 1'b1;
                        end
                    end
                    m_set[d][c] = (m_run[d][c] != 0);
                end
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_pop();
        exp_t e;
        logic [1:0][3:0] o_out, o_rise, o_fall, o_set;
        o_out  = {b_out,  a_out};
        o_rise = {b_rise, a_rise};
        o_fall = {b_fall, a_fall};
        o_set  = {b_set,  a_set};
        if (q.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL queue_empty observed=0 expected=1");
        end else begin
            e = q.pop_front();
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("dut%0d_out",  d), o_out[d],  e.out[d]);
                chk($sformatf("dut%0d_rise", d), o_rise[d], e.rise[d]);
                chk($sformatf("dut%0d_fall", d), o_fall[d], e.fall[d]);
                chk($sformatf("dut%0d_set",  d), o_set[d],  e.set[d]);
                chk($sformatf("dut%0d_excl", d), o_rise[d] & o_fall[d], 4'b0000);
            end
        end
    endtask

    // Drive one cycle's inputs, push the expected post-edge state, then compare
    // just after the rising edge.
    task automatic tick(input logic c_e, input logic s_r, input logic [3:0] din);
        exp_t e;
        ce          = c_e;
        synch_reset = s_r;
        data_in     = din;
        model_edge(c_e, s_r, din);
        e.out  = m_out;
        e.rise = m_rise;
        e.fall = m_fall;
        e.set  = m_set;
        q.push_back(e);
        @(posedge clk);
        #1;
        check_pop();
    endtask

    task automatic check_reset_state();
        chk("rst_a_out",  a_out,  4'hF);
        chk("rst_b_out",  b_out,  4'h0);
        chk("rst_a_rise", a_rise, 4'h0);
        chk("rst_a_fall", a_fall, 4'h0);
        chk("rst_a_set",  a_set,  4'h0);
        chk("rst_b_rise", b_rise, 4'h0);
        chk("rst_b_set",  b_set,  4'h0);
    endtask

    initial begin
        logic [3:0] din_r;

        // Reset state, no clock edge needed
        async_reset = 1'b1;
        ce          = 1'b0;
        synch_reset = 1'b0;
        data_in     = 4'b0000;
        model_reset();
        #3;
        check_reset_state();
        #4;
        async_reset = 1'b0;

        // Re-seed everything to zero
        tick(1'b1, 1'b1, 4'b0000);
        chk("seed_a_out", a_out, 4'b0000);

        // Rise on ch0: A after 10 edges, B after 3
        for (int k = 1; k <= 11; k++) begin
            tick(1'b1, 1'b0, 4'b0001);
            if (k == 3)  chk("rise_b_pulse3", b_rise, 4'b0001);
            if (k == 4)  chk("rise_b_pulse4", b_rise, 4'b0000);
            if (k == 9)  begin chk("rise_a_out9", a_out, 4'b0000); chk("rise_a_set9", a_set, 4'b0001); end
            if (k == 10) begin chk("rise_a_out10", a_out, 4'b0001); chk("rise_a_pulse10", a_rise, 4'b0001); end
            if (k == 11) begin chk("rise_a_pulse11", a_rise, 4'b0000); chk("rise_a_set11", a_set, 4'b0000); end
        end

        // Glitch on ch1: 9 high, 1 low, 9 high never reaches 10 on A
        for (int k = 1; k <= 9; k++) tick(1'b1, 1'b0, 4'b0011);
        chk("glitch_a_set_run", a_set, 4'b0010);
        tick(1'b1, 1'b0, 4'b0001);
        chk("glitch_a_set_break", a_set, 4'b0000);
        for (int k = 1; k <= 9; k++) tick(1'b1, 1'b0, 4'b0011);
        chk("glitch_a_out", a_out, 4'b0001);
        chk("glitch_a_set_end", a_set, 4'b0010);

        // Asymmetric fall: B falls after 7, A after 10
        for (int k = 1; k <= 11; k++) begin
            tick(1'b1, 1'b0, 4'b0000);
            if (k == 6)  chk("fall_b_out6", b_out, 4'b0011);
            if (k == 7)  begin chk("fall_b_out7", b_out, 4'b0000); chk("fall_b_pulse7", b_fall, 4'b0011); end
            if (k == 8)  chk("fall_b_pulse8", b_fall, 4'b0000);
            if (k == 10) begin chk("fall_a_out10", a_out, 4'b0000); chk("fall_a_pulse10", a_fall, 4'b0001); end
        end

        // CE every 4th clk: A ch2 flips on the 40th clk
        for (int k = 0; k < 44; k++) begin
            tick((k % 4) == 3, 1'b0, 4'b0100);
            if (k == 5)  chk("ce_a_set_hold", a_set, 4'b0100);
            if (k == 38) chk("ce_a_out38", a_out, 4'b0000);
            if (k == 39) begin chk("ce_a_out39", a_out, 4'b0100); chk("ce_a_pulse39", a_rise, 4'b0100); end
            if (k == 40) chk("ce_a_pulse40", a_rise, 4'b0000);
        end

        // Re-seed: ignored with CE=0, silent with CE=1
        tick(1'b1, 1'b1, 4'b0000);
        tick(1'b0, 1'b1, 4'b1010);
        chk("reseed_noce_a", a_out, 4'b0000);
        chk("reseed_noce_b", b_out, 4'b0000);
        tick(1'b1, 1'b1, 4'b1010);
        chk("reseed_a_out",  a_out,  4'b1010);
        chk("reseed_b_out",  b_out,  4'b1010);
        chk("reseed_a_rise", a_rise, 4'b0000);
        chk("reseed_a_set",  a_set,  4'b0000);

        // Async reset mid-run discards partial counts
        for (int k = 0; k < 5; k++) tick(1'b1, 1'b0, 4'b0101);
        async_reset = 1'b1;
        model_reset();
        #2;
        check_reset_state();
        #2;
        async_reset = 1'b0;

        // Random soak
        din_r = 4'b0101;
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 5) == 0) din_r[$urandom_range(0, 3)] ^= 1'b1;
            tick($urandom_range(0, 3) != 0, $urandom_range(0, 59) == 0, din_r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
